gray_code_counter: RTL and testbench

- Parametrised synchronous counter that holds its state in binary and presents registered binary and Gray outputs together.
- Supersedes the fixed 4-bit combinational binary-to-Gray converter with configurable width, up/down counting, and wrap or saturate mode.
- Supports synchronous load from either a binary or a Gray-encoded value.
- Used as a pointer and sequence source wherever single-bit-change encoding is required, such as clock-crossing pointers and encoder position emulation.

---
 rtl/gray_pkg.sv | 26 ++
 rtl/gray_to_binary.sv | 11 +
 rtl/gray_code_counter.sv | 56 +++++
 tb/tb_gray_code_counter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: shared width-generic Gray/binary conversion helpers and width limit
package gray_pkg;
    localparam int MAX_WIDTH = 32;

    typedef logic [MAX_WIDTH-1:0] word_t;

    function automatic word_t width_mask(input int w);
        return (w >= MAX_WIDTH) ? '1 : word_t'((64'd1 << w) - 64'd1);
    endfunction

    function automatic word_t bin2gray(input word_t b, input int w);
        word_t v;
        v = b & width_mask(w);
        return v ^ (v >> 1);
    endfunction

    // Bits above w are masked to zero, so the full-width prefix XOR is safe.
    function automatic word_t gray2bin(input word_t g, input int w);
        word_t v;
        word_t r;
        v = g & width_mask(w);
        r = v;
        for (int i = 1; i < MAX_WIDTH; i++) r = r ^ (v >> i);
        return r;
    endfunction
endpackage

// File: rtl/gray_to_binary.sv
// gray_to_binary: combinational prefix-XOR Gray decoder
module gray_to_binary #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] binary
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign binary[i] = ^gray[WIDTH-1:i];
    end
endmodule

// File: rtl/gray_code_counter.sv
// gray_code_counter: up/down binary counter with registered Gray output, wrap or saturate
module gray_code_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WRAP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_is_gray,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] gray,
    output logic             wrap,
    output logic             sat
);
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] next_gray;
    logic             limit;
    logic             blocked;

    gray_to_binary #(.WIDTH(WIDTH)) u_dec (
        .gray  (load_value),
        .binary(load_bin)
    );

    // Gray is computed from the next binary value so both flops update together.
    always_comb begin
        limit     = up ? (binary == '1) : (binary == '0);
        step      = up ? binary + WIDTH'(1) : binary - WIDTH'(1);
        blocked   = limit && (WRAP == 0);
        next_bin  = load ? (load_is_gray ? load_bin : load_value)
                         : ((en && !blocked) ? step : binary);
        next_gray = (load && load_is_gray) ? load_value
                                           : WIDTH'(bin2gray(MAX_WIDTH'(next_bin), WIDTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            binary <= '0;
            gray   <= '0;
            wrap   <= 1'b0;
            sat    <= 1'b0;
        end else begin
            binary <= next_bin;
            gray   <= next_gray;
            wrap   <= !load && en && limit && (WRAP != 0);
            sat    <= !load && en && blocked;
        end
    end
endmodule

// File: tb/tb_gray_code_counter.sv
// tb_gray_code_counter: directed and randomized checks of three counter configurations against an arithmetic model
module tb_gray_code_counter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic       load_is_gray = 1'b0;
    logic [7:0] load_value = '0;

    logic [3:0] b_a, g_a, b_b, g_b;
    logic [7:0] b_c, g_c;
    logic       w_a, s_a, w_b, s_b, w_c, s_c;

    always #5 clk = ~clk;

    gray_code_counter #(.WIDTH(4), .WRAP(1)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_is_gray(load_is_gray), .load_value(load_value[3:0]),
        .binary(b_a), .gray(g_a), .wrap(w_a), .sat(s_a)
    );
    gray_code_counter #(.WIDTH(4), .WRAP(0)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_is_gray(load_is_gray), .load_value(load_value[3:0]),
        .binary(b_b), .gray(g_b), .wrap(w_b), .sat(s_b)
    );
    gray_code_counter #(.WIDTH(8), .WRAP(1)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_is_gray(load_is_gray), .load_value(load_value),
        .binary(b_c), .gray(g_c), .wrap(w_c), .sat(s_c)
    );

    logic [7:0] d_bin [3];
    logic [7:0] d_gray[3];
    logic       d_wrap[3];
    logic       d_sat [3];

    always_comb begin
        d_bin[0]  = {4'b0, b_a};
        d_bin[1]  = {4'b0, b_b};
        d_bin[2]  = b_c;
        d_gray[0] = {4'b0, g_a};
        d_gray[1] = {4'b0, g_b};
        d_gray[2] = g_c;
        d_wrap[0] = w_a;
        d_wrap[1] = w_b;
        d_wrap[2] = w_c;
        d_sat[0]  = s_a;
        d_sat[1]  = s_b;
        d_sat[2]  = s_c;
    end

    int wid[3]   = '{4, 4, 8};
    bit wmode[3] = '{1'b1, 1'b0, 1'b1};
    int m_bin[3] = '{0, 0, 0};
    bit m_wrap[3] = '{1'b0, 1'b0, 1'b0};
    bit m_sat[3]  = '{1'b0, 1'b0, 1'b0};
    int total = 0;
    int bad = 0;

    // Gray decode as XOR of all right shifts of the code word.
    function automatic int g2b(input int g, input int w);
        int b = 0;
        for (int k = 0; k < w; k++) b = b ^ (g >> k);
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_bin[k]  = 0;
            m_wrap[k] = 1'b0;
            m_sat[k]  = 1'b0;
        end
    endtask

    task automatic tick(input bit l, input bit lg, input int lv, input bit e, input bit u);
        load = l;
        load_is_gray = lg;
        load_value = lv[7:0];
        en = e;
        up = u;
        for (int k = 0; k < 3; k++) begin
            int mx = (1 << wid[k]) - 1;
            int v = lv & mx;
            int n = u ? m_bin[k] + 1 : m_bin[k] - 1;
            m_wrap[k] = 1'b0;
            m_sat[k]  = 1'b0;
            if (l) m_bin[k] = lg ? g2b(v, wid[k]) : v;
            else if (e) begin
                if (n < 0 || n > mx) begin
                    if (wmode[k]) begin
                        m_bin[k]  = (n < 0) ? mx : 0;
                        m_wrap[k] = 1'b1;
                    end else m_sat[k] = 1'b1;
                end else m_bin[k] = n;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (d_bin[k] !== 8'd0 || d_gray[k] !== 8'd0 || d_wrap[k] !== 1'b0 || d_sat[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset dut%0d got bin=%0d gray=%0d wrap=%0b sat=%0b want all 0",
                         k, d_bin[k], d_gray[k], d_wrap[k], d_sat[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_free_run();
        logic [3:0] prev;
        int gseq[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
        total++;
        if (g_a !== 4'd0) begin
            bad++;
            $display("FAIL free_run start gray got=%0d want=0", g_a);
        end
        for (int i = 1; i < 16; i++) begin
            prev = g_a;
            tick(1'b0, 1'b0, 0, 1'b1, 1'b1);
            total++;
            if (g_a !== 4'(gseq[i]) || $countones(g_a ^ prev) != 1 || w_a !== 1'b0) begin
                bad++;
                $display("FAIL free_run step%0d got gray=%0d wrap=%0b want gray=%0d wrap=0 one-bit change",
                         i, g_a, w_a, gseq[i]);
            end
        end
        prev = g_a;
        tick(1'b0, 1'b0, 0, 1'b1, 1'b1);
        total++;
        if (b_a !== 4'd0 || g_a !== 4'd0 || w_a !== 1'b1 || $countones(g_a ^ prev) != 1) begin
            bad++;
            $display("FAIL free_run wrap got bin=%0d gray=%0d wrap=%0b want 0 0 1", b_a, g_a, w_a);
        end
        tick(1'b0, 1'b0, 0, 1'b0, 1'b1);
        total++;
        if (w_a !== 1'b0 || b_a !== 4'd0) begin
            bad++;
            $display("FAIL free_run wrap_pulse got wrap=%0b bin=%0d want wrap=0 bin=0", w_a, b_a);
        end
    endtask

    task automatic test_down_wrap();
        tick(1'b1, 1'b0, 1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 0, 1'b1, 1'b0);
        total++;
        if (b_a !== 4'd0 || w_a !== 1'b0) begin
            bad++;
            $display("FAIL down_wrap first got bin=%0d wrap=%0b want 0 0", b_a, w_a);
        end
        tick(1'b0, 1'b0, 0, 1'b1, 1'b0);
        total++;
        if (b_a !== 4'd15 || g_a !== 4'd8 || w_a !== 1'b1) begin
            bad++;
            $display("FAIL down_wrap second got bin=%0d gray=%0d wrap=%0b want 15 8 1", b_a, g_a, w_a);
        end
    endtask

    task automatic test_saturate();
        tick(1'b1, 1'b0, 14, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 0, 1'b1, 1'b1);
        total++;
        if (b_b !== 4'd15 || s_b !== 1'b0 || w_b !== 1'b0) begin
            bad++;
            $display("FAIL saturate step1 got bin=%0d sat=%0b wrap=%0b want 15 0 0", b_b, s_b, w_b);
        end
        for (int i = 2; i <= 3; i++) begin
            tick(1'b0, 1'b0, 0, 1'b1, 1'b1);
            total++;
            if (b_b !== 4'd15 || g_b !== 4'd8 || s_b !== 1'b1 || w_b !== 1'b0) begin
                bad++;
                $display("FAIL saturate step%0d got bin=%0d gray=%0d sat=%0b wrap=%0b want 15 8 1 0",
                         i, b_b, g_b, s_b, w_b);
            end
        end
    endtask

    task automatic test_gray_load();
        tick(1'b1, 1'b1, 'b1011, 1'b1, 1'b1);
        total++;
        if (g_a !== 4'b1011 || b_a !== 4'd13 || w_a !== 1'b0 || s_a !== 1'b0) begin
            bad++;
            $display("FAIL gray_load got gray=%0d bin=%0d wrap=%0b sat=%0b want 11 13 0 0", g_a, b_a, w_a, s_a);
        end
        total++;
        if (b_b !== 4'd13 || s_b !== 1'b0) begin
            bad++;
            $display("FAIL gray_load_sat got bin=%0d sat=%0b want 13 0", b_b, s_b);
        end
    endtask

    task automatic test_async_reset();
        tick(1'b1, 1'b0, 'h50, 1'b0, 1'b1);
        repeat (10) tick(1'b0, 1'b0, 0, 1'b1, 1'b1);
        total++;
        if (b_c !== 8'h5A) begin
            bad++;
            $display("FAIL async_pre got=%0h want=5a", b_c);
        end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (b_c !== 8'd0 || g_c !== 8'd0 || w_c !== 1'b0 || s_c !== 1'b0) begin
            bad++;
            $display("FAIL async_clear got bin=%0h gray=%0h want 0 0", b_c, g_c);
        end
        #2;
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 0, 1'b1, 1'b1);
        total++;
        if (b_c !== 8'd1 || g_c !== 8'd1) begin
            bad++;
            $display("FAIL async_restart got bin=%0d gray=%0d want 1 1", b_c, g_c);
        end
    endtask

    task automatic test_reversal();
        logic [3:0] prev;
        int eb[3] = '{6, 7, 6};
        int eg[3] = '{5, 4, 5};
        tick(1'b1, 1'b0, 7, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            prev = g_a;
            tick(1'b0, 1'b0, 0, 1'b1, (i == 1));
            total++;
            if (b_a !== 4'(eb[i]) || g_a !== 4'(eg[i]) || $countones(g_a ^ prev) != 1) begin
                bad++;
                $display("FAIL reversal step%0d got bin=%0d gray=%0d want bin=%0d gray=%0d",
                         i, b_a, g_a, eb[i], eg[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit l = ($urandom_range(7) == 0);
            tick(l, 1'($urandom), int'($urandom_range(255)), 1'($urandom_range(3) != 0), 1'($urandom));
            for (int k = 0; k < 3; k++) begin
                int eg = m_bin[k] ^ (m_bin[k] >> 1);
                total++;
                if (d_bin[k] !== 8'(m_bin[k]) || d_gray[k] !== 8'(eg) ||
                    d_wrap[k] !== m_wrap[k] || d_sat[k] !== m_sat[k]) begin
                    bad++;
                    $display("FAIL random it%0d dut%0d got bin=%0d gray=%0d wrap=%0b sat=%0b want %0d %0d %0b %0b",
                             i, k, d_bin[k], d_gray[k], d_wrap[k], d_sat[k], m_bin[k], eg, m_wrap[k], m_sat[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_down_wrap();
        test_saturate();
        test_gray_load();
        test_async_reset();
        test_reversal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
